// File: rtl/axis_fifo.sv
// ---------------------------------------------------------------------------
// axis_fifo
//   Parametrised AXI-stream FIFO. The head word lives in the registered odata
//   output; the remaining words (at most DEPTH-1) sit in a circular RAM with
//   wrapping read/write pointers. The occupancy, ready, valid and almost-full
//   outputs are all registered and are computed from the next occupancy.
//   A word pushed into an empty FIFO bypasses the RAM and goes straight into
//   odata.
//
// Parameters
//   WIDTH     data word width in bits
//   LOGDEPTH  log2 of capacity, DEPTH = 2**LOGDEPTH words (LOGDEPTH >= 1)
//   AFULL     almost_full threshold on size (1 <= AFULL <= DEPTH)
//
// Ports
//   clock        in   rising-edge clock
//   resetn       in   asynchronous active-low reset
//   flush        in   synchronous clear of all contents
//   size         out  words held, 0..DEPTH (includes the odata word)
//   almost_full  out  size >= AFULL
//   idata        in   input data
//   ivalid       in   input valid
//   iready       out  input ready
//   odata        out  output data (head word)
//   ovalid       out  output valid
//   oready       in   output ready
// ---------------------------------------------------------------------------
module axis_fifo #(
    parameter int unsigned WIDTH    = 8,
    parameter int unsigned LOGDEPTH = 3,
    parameter int unsigned AFULL    = 6
) (
    input  logic                clock,
    input  logic                resetn,
    input  logic                flush,
    output logic [LOGDEPTH:0]   size,
    output logic                almost_full,
    input  logic [WIDTH-1:0]    idata,
    input  logic                ivalid,
    output logic                iready,
    output logic [WIDTH-1:0]    odata,
    output logic                ovalid,
    input  logic                oready
);

    localparam int unsigned DEPTH     = 1 << LOGDEPTH;
    localparam int unsigned SW        = LOGDEPTH + 1;
    localparam int unsigned PW        = LOGDEPTH;
    localparam int unsigned RAM_WORDS = DEPTH - 1;
    localparam int unsigned RAM_LAST  = RAM_WORDS - 1;

    // Registered state
    logic [SW-1:0]    r_size;
    logic             r_ovalid;
    logic             r_iready;
    logic             r_afull;
    logic [WIDTH-1:0] r_odata;
    logic [WIDTH-1:0] r_ram [RAM_WORDS];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;

    // Combinational next-state terms
    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_ram_empty;
    logic             w_ram_rd;
    logic             w_ram_wr;
    logic             w_odata_en;
    logic [WIDTH-1:0] w_odata_next;
    logic [SW-1:0]    w_size_next;
    logic [PW-1:0]    w_wr_ptr_next;
    logic [PW-1:0]    w_rd_ptr_next;

    // Pointer advance wraps over the DEPTH-1 RAM slots.
    function automatic logic [PW-1:0] f_ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RAM_LAST)) ? '0 : p + PW'(1);
    endfunction

    // Handshakes: ready/valid are registered, so transfers use the flops.
    assign w_push = ivalid && r_iready;
    assign w_pop  = r_ovalid && oready;

    // odata may take a new word whenever it is empty or being consumed.
    assign w_load = !r_ovalid || oready;

    // RAM holds everything except the odata word.
    assign w_ram_empty = (r_size == SW'(r_ovalid));

    // Data-path steering: RAM head refills odata, otherwise idata bypasses.
    always_comb begin
        w_ram_rd     = 1'b0;
        w_ram_wr     = 1'b0;
        w_odata_en   = 1'b0;
        w_odata_next = r_odata;
        if (!flush) begin
            if (w_load) begin
                if (!w_ram_empty) begin
                    w_ram_rd     = 1'b1;
                    w_odata_en   = 1'b1;
                    w_odata_next = r_ram[r_rd_ptr];
                    w_ram_wr     = w_push;
                end else if (w_push) begin
                    w_odata_en   = 1'b1;
                    w_odata_next = idata;
                end
            end else begin
                // Stalled head: incoming word queues behind it in the RAM.
                w_ram_wr = w_push;
            end
        end
    end

    // Occupancy and pointer next values; flush discards this cycle's traffic.
    always_comb begin
        w_size_next   = r_size;
        w_wr_ptr_next = r_wr_ptr;
        w_rd_ptr_next = r_rd_ptr;
        if (flush) begin
            w_size_next   = '0;
            w_wr_ptr_next = '0;
            w_rd_ptr_next = '0;
        end else begin
            w_size_next = r_size + SW'(w_push) - SW'(w_pop);
            if (w_ram_wr) begin
                w_wr_ptr_next = f_ptr_inc(r_wr_ptr);
            end
            if (w_ram_rd) begin
                w_rd_ptr_next = f_ptr_inc(r_rd_ptr);
            end
        end
    end

    // Control registers, flags derived from the next occupancy.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_size   <= '0;
            r_ovalid <= 1'b0;
            r_iready <= 1'b1;
            r_afull  <= 1'b0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            r_size   <= w_size_next;
            r_ovalid <= (w_size_next != '0);
            r_iready <= (w_size_next < SW'(DEPTH));
            r_afull  <= (w_size_next >= SW'(AFULL));
            r_wr_ptr <= w_wr_ptr_next;
            r_rd_ptr <= w_rd_ptr_next;
        end
    end

    // Data storage; contents are undefined until written, so no reset.
    always_ff @(posedge clock) begin
        if (w_odata_en) begin
            r_odata <= w_odata_next;
        end
        if (w_ram_wr) begin
            r_ram[r_wr_ptr] <= idata;
        end
    end

    assign size        = r_size;
    assign almost_full = r_afull;
    assign iready      = r_iready;
    assign ovalid      = r_ovalid;
    assign odata       = r_odata;

endmodule

// File: tb/tb_axis_fifo.sv
// ---------------------------------------------------------------------------
// tb_axis_fifo
//   Self-checking bench for axis_fifo (WIDTH=8, LOGDEPTH=3, AFULL=6).
//   A queue model tracks accepted words; every falling edge the DUT outputs
//   are compared against it. Directed phases add literal expectations.
// ---------------------------------------------------------------------------
module tb_axis_fifo;

    localparam int WIDTH    = 8;
    localparam int LOGDEPTH = 3;
    localparam int DEPTH    = 8;
    localparam int AFULL    = 6;

    logic                clock;
    logic                resetn;
    logic                flush;
    logic [LOGDEPTH:0]   size;
    logic                almost_full;
    logic [WIDTH-1:0]    idata;
    logic                ivalid;
    logic                iready;
    logic [WIDTH-1:0]    odata;
    logic                ovalid;
    logic                oready;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    logic [WIDTH-1:0] q[$];

    axis_fifo #(
        .WIDTH   (WIDTH),
        .LOGDEPTH(LOGDEPTH),
        .AFULL   (AFULL)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .flush      (flush),
        .size       (size),
        .almost_full(almost_full),
        .idata      (idata),
        .ivalid     (ivalid),
        .iready     (iready),
        .odata      (odata),
        .ovalid     (ovalid),
        .oready     (oready)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change just after the falling edge, well away from the rising edge.
    task automatic step();
        @(negedge clock);
        #1;
    endtask

    // Reference model: transfer rules applied to a queue of accepted words.
    always @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            q.delete();
        end else if (flush) begin
            q.delete();
        end else begin
            bit do_push;
            bit do_pop;
            do_push = ivalid && (q.size() < DEPTH);
            do_pop  = oready && (q.size() > 0);
            if (do_pop)  void'(q.pop_front());
            if (do_push) q.push_back(idata);
        end
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (chk_en) begin
            check("size",        32'(size),        32'(q.size()));
            check("ovalid",      32'(ovalid),      32'(q.size() > 0));
            check("iready",      32'(iready),      32'(q.size() < DEPTH));
            check("almost_full", 32'(almost_full), 32'(q.size() >= AFULL));
            if (q.size() > 0) begin
                check("odata", 32'(odata), 32'(q[0]));
            end
        end
    end

    task automatic drain();
        ivalid = 1'b0;
        oready = 1'b1;
        repeat (DEPTH + 1) step();
        oready = 1'b0;
    endtask

    initial begin
        resetn = 1'b0;
        flush  = 1'b0;
        ivalid = 1'b0;
        oready = 1'b0;
        idata  = '0;
        repeat (2) step();
        check("rst_size",   32'(size),        32'd0);
        check("rst_ovalid", 32'(ovalid),      32'd0);
        check("rst_iready", 32'(iready),      32'd1);
        check("rst_afull",  32'(almost_full), 32'd0);
        resetn = 1'b1;
        step();
        chk_en = 1'b1;

        // Fill to full with the consumer stalled.
        for (int i = 0; i < DEPTH; i++) begin
            ivalid = 1'b1;
            idata  = 8'(8'h11 + i);
            step();
            check("fill_size",  32'(size),        32'(i + 1));
            check("fill_afull", 32'(almost_full), 32'((i + 1) >= 6));
            check("fill_odata", 32'(odata),       32'h11);
            check("fill_ready", 32'(iready),      32'((i + 1) < 8));
        end
        // Push attempt while full is ignored.
        idata = 8'h99;
        step();
        ivalid = 1'b0;
        check("full_hold_size", 32'(size), 32'd8);

        // Drain in acceptance order.
        oready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            check("drain_odata", 32'(odata), 32'(8'h11 + i));
            step();
            if (i == 0) check("drain_iready", 32'(iready), 32'd1);
            check("drain_size", 32'(size), 32'(7 - i));
        end
        check("drain_ovalid", 32'(ovalid), 32'd0);
        oready = 1'b0;

        // Bypass into an empty FIFO: one-cycle latency.
        ivalid = 1'b1;
        idata  = 8'hA5;
        step();
        ivalid = 1'b0;
        check("byp_ovalid", 32'(ovalid), 32'd1);
        check("byp_odata",  32'(odata),  32'hA5);
        check("byp_size",   32'(size),   32'd1);
        drain();

        // Steady streaming at size 3: output trails input by three words.
        for (int i = 0; i < 3; i++) begin
            ivalid = 1'b1;
            idata  = 8'(8'h30 + i);
            step();
        end
        oready = 1'b1;
        for (int i = 0; i < 6; i++) begin
            check("stream_odata", 32'(odata), 32'(8'h30 + i));
            idata = 8'(8'h33 + i);
            step();
            check("stream_size", 32'(size), 32'd3);
        end
        // Grow to size 5 (holding 0x36..0x3A), then flush with traffic.
        oready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            idata = 8'(8'h39 + i);
            step();
        end
        check("pre_flush_size",  32'(size),  32'd5);
        check("pre_flush_odata", 32'(odata), 32'h36);
        flush  = 1'b1;
        oready = 1'b1;
        idata  = 8'hEE;
        step();
        flush  = 1'b0;
        ivalid = 1'b0;
        oready = 1'b0;
        check("flush_size",   32'(size),        32'd0);
        check("flush_ovalid", 32'(ovalid),      32'd0);
        check("flush_iready", 32'(iready),      32'd1);
        check("flush_afull",  32'(almost_full), 32'd0);
        step();
        check("post_flush_size", 32'(size), 32'd0);
        ivalid = 1'b1;
        idata  = 8'h55;
        step();
        ivalid = 1'b0;
        check("post_flush_odata", 32'(odata), 32'h55);
        check("post_flush_size1", 32'(size),  32'd1);
        drain();

        // Random traffic with alternating bias to visit full and empty.
        for (int c = 0; c < 10000; c++) begin
            if (((c / 500) % 2) == 0) begin
                ivalid = ($urandom_range(0, 3) != 0);
                oready = ($urandom_range(0, 3) == 0);
            end else begin
                ivalid = ($urandom_range(0, 3) == 0);
                oready = ($urandom_range(0, 3) != 0);
            end
            idata = 8'($urandom);
            flush = ($urandom_range(0, 199) == 0);
            resetn = !(c == 7000);
            step();
        end
        resetn = 1'b1;
        flush  = 1'b0;
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
